ps2_kbd_ctrl: RTL and testbench

//  Sequencer between the ps2_keyboard receiver FIFO and the six bcd7seg digits.
//  - Pops scan-code bytes through the ready/nextdata_n handshake.
//  - Decodes make, break (F0 prefix) and extended (E0 prefix) sequences into key events.
//  - Keeps a BCD count of key presses and drives the six display nibbles plus per-digit blanks.

---
 rtl/kbd_pkg.sv | 24 ++
 rtl/kbd_byte_fetch.sv | 57 +++++
 rtl/ps2_kbd_ctrl.sv | 106 ++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants, fetch FSM states and BCD helper for the PS/2 keyboard sequencer.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {IDLE, POP, SETTLE, DECODE} fetch_state_t;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo >= 4'd9) begin
      lo = 4'd0;
      hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

endpackage

// File: rtl/kbd_byte_fetch.sv
// Pops one byte at a time from the receiver FIFO and presents it with a one-cycle byte_vld.
module kbd_byte_fetch
  import kbd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] data,
  output logic       nextdata_n,
  output logic [7:0] byte_r,
  output logic       byte_vld
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  fetch_state_t  state;
  logic [CW-1:0] cnt;

  // The FIFO head changes after a pop, so ready/data are only trusted back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      nextdata_n <= 1'b1;
      byte_r     <= 8'h00;
      byte_vld   <= 1'b0;
      cnt        <= '0;
    end else begin
      nextdata_n <= 1'b1;
      byte_vld   <= 1'b0;
      case (state)
        IDLE: begin
          if (ready) begin
            byte_r     <= data;
            nextdata_n <= 1'b0;
            state      <= POP;
          end
        end
        POP: begin
          cnt   <= CW'(SETTLE_CYCLES);
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) begin
            state    <= DECODE;
            byte_vld <= 1'b1;
          end
        end
        DECODE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencer: scan-code decode, BCD press counter and six-digit display drive.
// Optional KBD_TYPEMATIC_FILTER_EN: repeated makes of the held key are not counted.
module ps2_kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1,
  parameter bit BLANK_RELEASED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [7:0]  data,
  input  logic        overflow,
  output logic        nextdata_n,
  output logic [7:0]  key_code,
  output logic        key_ext,
  output logic        key_down,
  output logic        key_event,
  output logic [7:0]  press_cnt,
  output logic        ovf_err,
  output logic [23:0] disp_nib,
  output logic [5:0]  disp_blank
);

  logic [7:0] byte_r;
  logic       byte_vld;
  logic       brk_p;
  logic       ext_p;
  logic [7:0] held_code;
  logic       held_ext;
  logic       held_vld;
  logic       held_match;
  logic       repeat_make;

  kbd_byte_fetch #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_fetch (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .data       (data),
    .nextdata_n (nextdata_n),
    .byte_r     (byte_r),
    .byte_vld   (byte_vld)
  );

  assign held_match = held_vld && (held_code == byte_r) && (held_ext == ext_p);

`ifdef KBD_TYPEMATIC_FILTER_EN
  assign repeat_make = held_match;
`else
  assign repeat_make = 1'b0;
`endif

  // Prefixes accumulate until a non-prefix byte completes the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_down  <= 1'b0;
      key_event <= 1'b0;
      press_cnt <= 8'h00;
      ovf_err   <= 1'b0;
      brk_p     <= 1'b0;
      ext_p     <= 1'b0;
      held_code <= 8'h00;
      held_ext  <= 1'b0;
      held_vld  <= 1'b0;
    end else begin
      key_event <= 1'b0;
      ovf_err   <= ovf_err | overflow;
      if (byte_vld) begin
        if (byte_r == SC_BREAK) begin
          brk_p <= 1'b1;
        end else if (byte_r == SC_EXT) begin
          ext_p <= 1'b1;
        end else begin
          key_code  <= byte_r;
          key_ext   <= ext_p;
          key_down  <= ~brk_p;
          key_event <= 1'b1;
          brk_p     <= 1'b0;
          ext_p     <= 1'b0;
          if (!brk_p) begin
            held_code <= byte_r;
            held_ext  <= ext_p;
            held_vld  <= 1'b1;
            if (!repeat_make) press_cnt <= bcd_inc(press_cnt);
          end else if (held_match) begin
            held_vld <= 1'b0;
          end
        end
      end
    end
  end

  // Display follows one cycle behind the event so it sees the updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_nib   <= 24'h000000;
      disp_blank <= 6'b111111;
    end else if (key_event) begin
      disp_nib   <= {press_cnt, key_code, held_code};
      disp_blank <= {4'b0000, (BLANK_RELEASED && !held_vld) ? 2'b11 : 2'b00};
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: FIFO model feeds bytes, a monitor checks each key event.
module tb_ps2_kbd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        overflow = 1'b0;
  logic        nextdata_n;
  logic [7:0]  key_code;
  logic        key_ext;
  logic        key_down;
  logic        key_event;
  logic [7:0]  press_cnt;
  logic        ovf_err;
  logic [23:0] disp_nib;
  logic [5:0]  disp_blank;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       down;
    logic [7:0] cnt;
    logic [1:0] blk;
    logic [7:0] lo;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  exp_t       pend_exp;
  bit         pend = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pops = 0;
  int         last_pop = -100;

  always #5 clk = ~clk;

  ps2_kbd_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .data       (data),
    .overflow   (overflow),
    .nextdata_n (nextdata_n),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_down   (key_down),
    .key_event  (key_event),
    .press_cnt  (press_cnt),
    .ovf_err    (ovf_err),
    .disp_nib   (disp_nib),
    .disp_blank (disp_blank)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic pushExp(input logic [7:0] code, input logic ext, input logic down,
                         input logic [7:0] cnt, input logic [1:0] blk, input logic [7:0] lo);
    exp_t e;
    e.code = code; e.ext = ext; e.down = down; e.cnt = cnt; e.blk = blk; e.lo = lo;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'((n / 10) % 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0 || pend || nextdata_n == 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d events still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_nextdata_n"}, 32'(nextdata_n), 32'h1);
    checkOutput({tag, "_key_code"},   32'(key_code),   32'h0);
    checkOutput({tag, "_key_ext"},    32'(key_ext),    32'h0);
    checkOutput({tag, "_key_down"},   32'(key_down),   32'h0);
    checkOutput({tag, "_key_event"},  32'(key_event),  32'h0);
    checkOutput({tag, "_press_cnt"},  32'(press_cnt),  32'h0);
    checkOutput({tag, "_ovf_err"},    32'(ovf_err),    32'h0);
    checkOutput({tag, "_disp_nib"},   32'(disp_nib),   32'h0);
    checkOutput({tag, "_disp_blank"}, 32'(disp_blank), 32'h3F);
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: pops on the negedge inside a nextdata_n low cycle, then refreshes head.
  always @(negedge clk) begin
    if (nextdata_n == 1'b0) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pops++;
      checkOutput("pop_gap_ge4", 32'((cyc - last_pop) >= 4), 32'h1);
      last_pop = cyc;
    end
    ready = (fifo_q.size() > 0);
    data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  // Monitor: event fields on the key_event cycle, display one cycle later.
  always @(negedge clk) begin
    if (pend) begin
      checkOutput("disp_cnt",   32'(disp_nib[23:16]), 32'(pend_exp.cnt));
      checkOutput("disp_code",  32'(disp_nib[15:8]),  32'(pend_exp.code));
      checkOutput("disp_blank", 32'(disp_blank),      32'({4'b0000, pend_exp.blk}));
      if (pend_exp.blk == 2'b00)
        checkOutput("disp_held", 32'(disp_nib[7:0]), 32'(pend_exp.lo));
      pend = 1'b0;
    end
    if (key_event) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got code %0h, required no event", key_code);
      end else begin
        pend_exp = exp_q.pop_front();
        checkOutput("ev_code",  32'(key_code),  32'(pend_exp.code));
        checkOutput("ev_ext",   32'(key_ext),   32'(pend_exp.ext));
        checkOutput("ev_down",  32'(key_down),  32'(pend_exp.down));
        checkOutput("ev_count", 32'(press_cnt), 32'(pend_exp.cnt));
        pend = 1'b1;
      end
    end
  end

  initial begin
    int p0;
    int n;
    logic [7:0] c;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetState("reset");

    // Single make
    p0 = pops;
    applyStimulus(8'h1C);
    pushExp(8'h1C, 1'b0, 1'b1, 8'h01, 2'b00, 8'h1C);
    waitIdle(200);
    checkOutput("t1_pops", 32'(pops - p0), 32'd1);

    // Break of held key blanks digits 1:0
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    pushExp(8'h1C, 1'b0, 1'b0, 8'h01, 2'b11, 8'h1C);
    // Non-matching breaks leave the held key alone
    applyStimulus(8'h2A);
    pushExp(8'h2A, 1'b0, 1'b1, 8'h02, 2'b00, 8'h2A);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    pushExp(8'h1C, 1'b0, 1'b0, 8'h02, 2'b00, 8'h2A);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h2A);
    pushExp(8'h2A, 1'b1, 1'b0, 8'h02, 2'b00, 8'h2A);
    applyStimulus(8'hF0); applyStimulus(8'h2A);
    pushExp(8'h2A, 1'b0, 1'b0, 8'h02, 2'b11, 8'h2A);
    waitIdle(400);

    // Extended break, both prefix orders, repeated prefixes
    p0 = pops;
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    pushExp(8'h75, 1'b1, 1'b0, 8'h02, 2'b11, 8'h00);
    waitIdle(200);
    checkOutput("t3_pops", 32'(pops - p0), 32'd3);
    applyStimulus(8'hF0); applyStimulus(8'hE0); applyStimulus(8'h6B);
    pushExp(8'h6B, 1'b1, 1'b0, 8'h02, 2'b11, 8'h00);
    applyStimulus(8'hE0); applyStimulus(8'hE0); applyStimulus(8'hF0);
    applyStimulus(8'hF0); applyStimulus(8'h74);
    pushExp(8'h74, 1'b1, 1'b0, 8'h02, 2'b11, 8'h00);
    applyStimulus(8'hE0); applyStimulus(8'h70);
    pushExp(8'h70, 1'b1, 1'b1, 8'h03, 2'b00, 8'h70);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h70);
    pushExp(8'h70, 1'b1, 1'b0, 8'h03, 2'b11, 8'h70);
    waitIdle(400);

    doReset();
    checkResetState("reset2");

    // Counter wrap over 100 make/break pairs
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(8'h16); applyStimulus(8'hF0); applyStimulus(8'h16);
      c = to_bcd(i % 100);
      pushExp(8'h16, 1'b0, 1'b1, c, 2'b00, 8'h16);
      pushExp(8'h16, 1'b0, 1'b0, c, 2'b11, 8'h16);
    end
    waitIdle(5000);
    checkOutput("t4_wrap", 32'(press_cnt), 32'h00);

    doReset();

    // Typematic repeat
    applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
`ifdef KBD_TYPEMATIC_FILTER_EN
    pushExp(8'h1C, 1'b0, 1'b1, 8'h01, 2'b00, 8'h1C);
    pushExp(8'h1C, 1'b0, 1'b1, 8'h01, 2'b00, 8'h1C);
    pushExp(8'h1C, 1'b0, 1'b1, 8'h01, 2'b00, 8'h1C);
    pushExp(8'h1C, 1'b0, 1'b0, 8'h01, 2'b11, 8'h1C);
    waitIdle(300);
    checkOutput("t5_count", 32'(press_cnt), 32'h01);
`else
    pushExp(8'h1C, 1'b0, 1'b1, 8'h01, 2'b00, 8'h1C);
    pushExp(8'h1C, 1'b0, 1'b1, 8'h02, 2'b00, 8'h1C);
    pushExp(8'h1C, 1'b0, 1'b1, 8'h03, 2'b00, 8'h1C);
    pushExp(8'h1C, 1'b0, 1'b0, 8'h03, 2'b11, 8'h1C);
    waitIdle(300);
    checkOutput("t5_count", 32'(press_cnt), 32'h03);
`endif

    // Sticky overflow, decoding continues
    @(negedge clk);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    checkOutput("ovf_set", 32'(ovf_err), 32'h1);
    repeat (5) @(negedge clk);
    checkOutput("ovf_sticky", 32'(ovf_err), 32'h1);
    applyStimulus(8'h3C);
`ifdef KBD_TYPEMATIC_FILTER_EN
    pushExp(8'h3C, 1'b0, 1'b1, 8'h02, 2'b00, 8'h3C);
`else
    pushExp(8'h3C, 1'b0, 1'b1, 8'h04, 2'b00, 8'h3C);
`endif
    waitIdle(200);
    checkOutput("ovf_still", 32'(ovf_err), 32'h1);

    // Reset during POP abandons the pop and loses the byte
    applyStimulus(8'h1C);
    n = 0;
    while (nextdata_n !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_saw_pop", 32'(nextdata_n == 1'b0), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("rst_in_pop");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("t6_byte_lost", 32'(fifo_q.size()), 32'd0);
    checkOutput("t6_no_count", 32'(press_cnt), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
